// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and a buffered MDU result stream,
// tracking in-flight MDU destinations for decode hazard checks. Optional forwarding outputs: RF_BYPASS_EN.
module rf_write_arbiter #(
  parameter int AW         = 5,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_waddr,
  input  logic [DW-1:0] pipe_wdata,
  output logic          pipe_stall,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [AW-1:0] mdu_waddr,
  input  logic [DW-1:0] mdu_wdata,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_addr,
  input  logic [AW-1:0] rAddr,
  input  logic [AW-1:0] rAddr2,
  output logic          busy1,
  output logic          busy2,
  output logic [AW-1:0] wAddr,
  output logic [DW-1:0] wIn,
  output logic          wEna
`ifdef RF_BYPASS_EN
  ,
  output logic          fwd1_hit,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd_data
`endif
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(STARVE_LIM + 2);
  localparam int NREG = 1 << AW;

  logic [AW-1:0]   r_fifoAddr [FIFO_DEPTH];
  logic [DW-1:0]   r_fifoData [FIFO_DEPTH];
  logic [PW:0]     r_wrPtr;
  logic [PW:0]     r_rdPtr;
  logic            r_readyEn;
  logic [CW-1:0]   r_age;
  logic [NREG-1:0] r_pending;
  logic            r_pipeStall;
  logic            r_wEna;
  logic [AW-1:0]   r_wAddr;
  logic [DW-1:0]   r_wIn;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_headAddr;
  logic [DW-1:0]   w_headData;
  logic [CW-1:0]   w_ageNext;
  logic [NREG-1:0] w_pendingNext;

  assign w_empty    = (r_wrPtr == r_rdPtr);
  assign w_full     = (r_wrPtr[PW-1:0] == r_rdPtr[PW-1:0]) && (r_wrPtr[PW] != r_rdPtr[PW]);
  // Held low until the first edge after reset so nothing is accepted while rst is still settling.
  assign mdu_ready  = r_readyEn && !w_full;
  assign w_push     = mdu_valid && mdu_ready;
  assign w_pop      = !pipe_we && !w_empty;
  assign w_headAddr = r_fifoAddr[r_rdPtr[PW-1:0]];
  assign w_headData = r_fifoData[r_rdPtr[PW-1:0]];

  // Saturates one past the limit so a stall-ignoring pipeline cannot re-trigger the stall.
  always_comb begin
    w_ageNext = r_age;
    if (w_pop) begin
      w_ageNext = '0;
    end else if (pipe_we && !w_empty && (r_age != CW'(STARVE_LIM + 1))) begin
      w_ageNext = r_age + 1'b1;
    end
  end

  // A new issue to the address being retired must stay pending, so the set is applied last.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_pop) begin
      w_pendingNext[w_headAddr] = 1'b0;
    end
    if (issue_en && (issue_addr != '0)) begin
      w_pendingNext[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_readyEn   <= 1'b0;
      r_age       <= '0;
      r_pending   <= '0;
      r_pipeStall <= 1'b0;
      r_wEna      <= 1'b0;
      r_wAddr     <= '0;
      r_wIn       <= '0;
    end else begin
      r_readyEn   <= 1'b1;
      r_age       <= w_ageNext;
      r_pending   <= w_pendingNext;
      r_pipeStall <= (w_ageNext == CW'(STARVE_LIM));
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (pipe_we) begin
        r_wEna  <= (pipe_waddr != '0);
        r_wAddr <= pipe_waddr;
        r_wIn   <= pipe_wdata;
      end else if (w_pop) begin
        r_wEna  <= (w_headAddr != '0);
        r_wAddr <= w_headAddr;
        r_wIn   <= w_headData;
      end else begin
        r_wEna  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoAddr[r_wrPtr[PW-1:0]] <= mdu_waddr;
      r_fifoData[r_wrPtr[PW-1:0]] <= mdu_wdata;
    end
  end

  assign pipe_stall = r_pipeStall;
  assign wEna       = r_wEna;
  assign wAddr      = r_wAddr;
  assign wIn        = r_wIn;
  assign busy1      = r_pending[rAddr] && (rAddr != '0);
  assign busy2      = r_pending[rAddr2] && (rAddr2 != '0);

`ifdef RF_BYPASS_EN
  assign fwd1_hit = r_wEna && (r_wAddr == rAddr) && (rAddr != '0);
  assign fwd2_hit = r_wEna && (r_wAddr == rAddr2) && (rAddr2 != '0);
  assign fwd_data = r_wIn;
`endif

  a_noPipeWeDuringStall: assert property (@(posedge clk) disable iff (rst) !(pipe_stall && pipe_we));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: expected register-file writes are queued as stimulus is
// issued and a negedge monitor retires them against wEna/wAddr/wIn; status outputs are checked directly.
module tb_rf_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          pipe_we;
  logic [AW-1:0] pipe_waddr;
  logic [DW-1:0] pipe_wdata;
  logic          pipe_stall;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_waddr;
  logic [DW-1:0] mdu_wdata;
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic [AW-1:0] rAddr;
  logic [AW-1:0] rAddr2;
  logic          busy1;
  logic          busy2;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] wIn;
  logic          wEna;
`ifdef RF_BYPASS_EN
  logic          fwd1_hit;
  logic          fwd2_hit;
  logic [DW-1:0] fwd_data;
`endif

  int checkCount = 0;
  int passCount  = 0;
  logic [AW+DW-1:0] expQ [$];

  rf_write_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(2), .STARVE_LIM(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we    (pipe_we),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .pipe_stall (pipe_stall),
    .mdu_valid  (mdu_valid),
    .mdu_ready  (mdu_ready),
    .mdu_waddr  (mdu_waddr),
    .mdu_wdata  (mdu_wdata),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .rAddr      (rAddr),
    .rAddr2     (rAddr2),
    .busy1      (busy1),
    .busy2      (busy2),
    .wAddr      (wAddr),
    .wIn        (wIn),
    .wEna       (wEna)
`ifdef RF_BYPASS_EN
    ,
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd_data   (fwd_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Every observed write retires the oldest expected one; writes with nothing queued are flagged.
  always @(negedge clk) begin
    logic [AW+DW-1:0] expWord;
    if (!rst && wEna) begin
      checkCount++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_write: got addr %0d data %h, required no write", wAddr, wIn);
      end else begin
        expWord = expQ.pop_front();
        if ({wAddr, wIn} === expWord) begin
          passCount++;
        end else begin
          $display("[TB] FAIL rf_write: got addr %0d data %h, required addr %0d data %h",
                   wAddr, wIn, expWord[AW+DW-1:DW], expWord[DW-1:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic pwe, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                               input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                               input logic ie, input logic [AW-1:0] ia);
    pipe_we    = pwe;
    pipe_waddr = pa;
    pipe_wdata = pd;
    mdu_valid  = mv;
    mdu_waddr  = ma;
    mdu_wdata  = md;
    issue_en   = ie;
    issue_addr = ia;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic pushExp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    expQ.push_back({a, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rAddr = '0;
    rAddr2 = '0;
    idle();

    // Reset values, then mdu_ready only after the first edge following release.
    sample();
    checkOutput("rst_wEna", {31'd0, wEna}, 32'd0);
    checkOutput("rst_wAddr", {27'd0, wAddr}, 32'd0);
    checkOutput("rst_wIn", wIn, 32'd0);
    checkOutput("rst_stall", {31'd0, pipe_stall}, 32'd0);
    checkOutput("rst_ready", {31'd0, mdu_ready}, 32'd0);
    step();
    rst = 1'b0;
    sample();
    checkOutput("ready_before_edge", {31'd0, mdu_ready}, 32'd0);
    step();
    sample();
    checkOutput("ready_after_edge", {31'd0, mdu_ready}, 32'd1);
    step();

    // Pipeline write, then a pipeline write to address 0 that must not raise wEna.
    applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 1'b0, '0);
    pushExp(5'd5, 32'h1234);
    step();
    idle();
    sample();
    step();
    applyStimulus(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, 1'b0, '0);
    step();
    idle();
    sample();
    checkOutput("addr0_wEna", {31'd0, wEna}, 32'd0);
    step();

    // Issued op to r7, its MDU result lands two cycles after being offered.
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'hABCD, 1'b0, '0);
    pushExp(5'd7, 32'hABCD);
    rAddr = 5'd7;
    sample();
    checkOutput("busy_after_issue", {31'd0, busy1}, 32'd1);
    checkOutput("mdu_ready_idle", {31'd0, mdu_ready}, 32'd1);
    step();
    idle();
    sample();
    checkOutput("mdu_no_passthru", {31'd0, wEna}, 32'd0);
    checkOutput("busy_while_queued", {31'd0, busy1}, 32'd1);
    step();
    sample();
    checkOutput("busy_after_pop", {31'd0, busy1}, 32'd0);
    step();

    // Fill the FIFO while the pipeline keeps winning; stall follows the fourth lost cycle.
    applyStimulus(1'b1, 5'd1, 32'h1000, 1'b1, 5'd10, 32'hA0A0, 1'b0, '0);
    pushExp(5'd1, 32'h1000);
    sample();
    checkOutput("fill_ready0", {31'd0, mdu_ready}, 32'd1);
    step();
    applyStimulus(1'b1, 5'd2, 32'h1001, 1'b1, 5'd11, 32'hB1B1, 1'b0, '0);
    pushExp(5'd2, 32'h1001);
    sample();
    checkOutput("fill_ready1", {31'd0, mdu_ready}, 32'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 5'(3 + k), 32'h1002 + 32'(k), 1'b0, '0, '0, 1'b0, '0);
      pushExp(5'(3 + k), 32'h1002 + 32'(k));
      sample();
      checkOutput($sformatf("full_ready_%0d", k), {31'd0, mdu_ready}, 32'd0);
      checkOutput($sformatf("no_stall_%0d", k), {31'd0, pipe_stall}, 32'd0);
      step();
    end
    idle();
    pushExp(5'd10, 32'hA0A0);
    pushExp(5'd11, 32'hB1B1);
    sample();
    checkOutput("starve_stall", {31'd0, pipe_stall}, 32'd1);
    checkOutput("full_pop_ready", {31'd0, mdu_ready}, 32'd0);
    step();
    sample();
    checkOutput("stall_one_cycle", {31'd0, pipe_stall}, 32'd0);
    checkOutput("ready_after_drain", {31'd0, mdu_ready}, 32'd1);
    step();
    sample();
    step();

    // Re-issue to r9 on the same edge its older result pops: r9 must stay busy.
    rAddr = 5'd9;
    rAddr2 = 5'd9;
    applyStimulus(1'b1, 5'd2, 32'h2222, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9);
    pushExp(5'd2, 32'h2222);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
    pushExp(5'd9, 32'h99);
    sample();
    checkOutput("busy9_before", {31'd0, busy1}, 32'd1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h999, 1'b0, '0);
    pushExp(5'd9, 32'h999);
    sample();
    checkOutput("same_edge_busy1", {31'd0, busy1}, 32'd1);
    checkOutput("same_edge_busy2", {31'd0, busy2}, 32'd1);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd0);
    sample();
    step();
    idle();
    rAddr2 = 5'd0;
    sample();
    checkOutput("busy9_cleared", {31'd0, busy1}, 32'd0);
    checkOutput("busy_addr0", {31'd0, busy2}, 32'd0);
    step();

`ifdef RF_BYPASS_EN
    applyStimulus(1'b1, 5'd3, 32'h3333, 1'b0, '0, '0, 1'b0, '0);
    pushExp(5'd3, 32'h3333);
    step();
    idle();
    rAddr = 5'd3;
    rAddr2 = 5'd4;
    sample();
    checkOutput("fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
    checkOutput("fwd2_miss", {31'd0, fwd2_hit}, 32'd0);
    checkOutput("fwd_data", fwd_data, 32'h3333);
    step();
    applyStimulus(1'b1, 5'd0, 32'h4444, 1'b0, '0, '0, 1'b0, '0);
    step();
    idle();
    rAddr = 5'd0;
    rAddr2 = 5'd0;
    sample();
    checkOutput("fwd1_addr0", {31'd0, fwd1_hit}, 32'd0);
    checkOutput("fwd2_addr0", {31'd0, fwd2_hit}, 32'd0);
    step();
`endif

    // Reset with two buffered MDU results: nothing stale may be written afterwards.
    applyStimulus(1'b1, 5'd1, 32'h5000, 1'b1, 5'd12, 32'hC0C0, 1'b1, 5'd12);
    pushExp(5'd1, 32'h5000);
    step();
    applyStimulus(1'b1, 5'd2, 32'h5001, 1'b1, 5'd13, 32'hD0D0, 1'b0, '0);
    rAddr = 5'd12;
    sample();
    checkOutput("pre_rst_busy", {31'd0, busy1}, 32'd1);
    step();
    rst = 1'b1;
    idle();
    sample();
    checkOutput("mid_rst_wEna", {31'd0, wEna}, 32'd0);
    checkOutput("mid_rst_ready", {31'd0, mdu_ready}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy1}, 32'd0);
    checkOutput("mid_rst_stall", {31'd0, pipe_stall}, 32'd0);
    step();
    sample();
    step();
    rst = 1'b0;
    sample();
    checkOutput("post_rst_ready0", {31'd0, mdu_ready}, 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      sample();
      step();
    end
    sample();
    checkOutput("post_rst_ready1", {31'd0, mdu_ready}, 32'd1);
    checkOutput("post_rst_busy", {31'd0, busy1}, 32'd0);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
